// File: rtl/cam_capture_rgb565.sv
// DVP camera capture: pairs bytes into RGB565, decimates, converts to RGB12 and issues draw-point writes.
// States: IDLE (settle-skip / wait for enabled frame), SYNC (wait VSync fall), ACTIVE (capturing lines).
module cam_capture_rgb565 #(
    parameter int HRES        = 640,
    parameter int VRES        = 480,
    parameter int DECIMATE    = 2,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset_n,
    input  logic        piul1Enable,
    input  logic        piul1VSync,
    input  logic        piul1HRef,
    input  logic [7:0]  piul8Data,
    output logic [8:0]  poul9PosX,
    output logic [8:0]  poul9PosY,
    output logic [11:0] poul12Rgb12Data,
    output logic        poul1Update,
    output logic        poul1FrameDone,
    output logic        poul1Busy,
    output logic [15:0] poul16FrameCount,
    output logic        poul1LineError
);

    localparam int CW = $clog2(HRES + 1);
    localparam int RW = $clog2(VRES + 1);
    localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_skip_cnt;
    logic            r_vsync_d, r_href_d;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_phase;
    logic [6:0]      r_hi_bits;
    logic [8:0]      r_pos_x, r_pos_y;
    logic [11:0]     r_rgb12;
    logic            r_update, r_frame_done, r_line_error;
    logic [15:0]     r_frame_count;

    logic            w_vs_rise, w_vs_fall, w_hr_fall;
    logic            w_skip_inc, w_frame_start, w_line_end, w_frame_end, w_byte;
    logic [RW-1:0]   w_row_inc, w_row_after;
    logic            w_line_bad, w_frame_bad, w_in_win, w_keep, w_write;

    assign w_vs_rise = piul1VSync & ~r_vsync_d;
    assign w_vs_fall = ~piul1VSync & r_vsync_d;
    assign w_hr_fall = ~piul1HRef & r_href_d;

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_skip_inc    = 1'b0;
        w_frame_start = 1'b0;
        w_line_end    = 1'b0;
        w_frame_end   = 1'b0;
        w_byte        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise) begin
                    if (r_skip_cnt < SW'(SKIP_FRAMES)) w_skip_inc  = 1'b1;
                    else if (piul1Enable)              w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_vs_fall) begin
                    w_state_nxt   = S_ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                w_byte     = piul1HRef;
                w_line_end = w_hr_fall;
                if (w_vs_rise) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = piul1Enable ? S_SYNC : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line end is folded in before the frame-end row check so a coincident HRef fall counts.
    assign w_row_inc   = (r_row < RW'(VRES)) ? r_row + RW'(1) : r_row;
    assign w_row_after = w_line_end ? w_row_inc : r_row;
    assign w_line_bad  = w_line_end && (r_row < RW'(VRES)) && ((r_col != CW'(HRES)) || r_phase);
    assign w_frame_bad = w_frame_end && (w_row_after != RW'(VRES));
    assign w_in_win    = (r_col < CW'(HRES)) && (r_row < RW'(VRES));
    assign w_keep      = (DECIMATE == 1) || (!r_col[0] && !r_row[0]);
    assign w_write     = w_byte && r_phase && w_in_win && w_keep;

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            r_skip_cnt    <= '0;
            r_vsync_d     <= 1'b0;
            r_href_d      <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_phase       <= 1'b0;
            r_hi_bits     <= '0;
            r_pos_x       <= '0;
            r_pos_y       <= '0;
            r_rgb12       <= '0;
            r_update      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_line_error  <= 1'b0;
        end else begin
            r_vsync_d    <= piul1VSync;
            r_href_d     <= piul1HRef;
            r_update     <= w_write;
            r_frame_done <= w_frame_end;
            if (w_skip_inc) r_skip_cnt <= r_skip_cnt + SW'(1);
            if (w_frame_start) begin
                r_col   <= '0;
                r_row   <= '0;
                r_phase <= 1'b0;
            end else if (w_line_end) begin
                r_col   <= '0;
                r_row   <= w_row_inc;
                r_phase <= 1'b0;
            end else if (w_byte) begin
                r_phase <= ~r_phase;
                if (!r_phase)                 r_hi_bits <= {piul8Data[7:4], piul8Data[2:0]};
                else if (r_col < CW'(HRES))   r_col     <= r_col + CW'(1);
            end
            if (w_write) begin
                r_pos_x <= 9'(r_col >> (DECIMATE - 1));
                r_pos_y <= 9'(r_row >> (DECIMATE - 1));
                r_rgb12 <= {r_hi_bits[6:3], r_hi_bits[2:0], piul8Data[7], piul8Data[4:1]};
            end
            if (w_frame_end)              r_frame_count <= r_frame_count + 16'd1;
            if (w_line_bad || w_frame_bad) r_line_error  <= 1'b1;
        end
    end

    assign poul9PosX        = r_pos_x;
    assign poul9PosY        = r_pos_y;
    assign poul12Rgb12Data  = r_rgb12;
    assign poul1Update      = r_update;
    assign poul1FrameDone   = r_frame_done;
    assign poul1Busy        = (r_state != S_IDLE);
    assign poul16FrameCount = r_frame_count;
    assign poul1LineError   = r_line_error;

endmodule
